// File: rtl/sram_wbqueue_pkg.sv
// Shared types for the SRAM request queue: downstream FSM encoding and request word layout.
package sram_wbqueue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    // Queue entry is {we, addr, data, sel}
    function automatic int req_width(input int aw);
        return 1 + aw + DATA_W + SEL_W;
    endfunction

endpackage

// File: rtl/sram_reqfifo.sv
// Small synchronous request FIFO with flush; head is read combinationally so the
// consumer can load it on the same edge it pops.
module sram_reqfifo #(
    parameter int DW     = 52,
    parameter int LGFIFO = 2
) (
    input  logic              i_clk,
    input  logic              i_areset_n,
    input  logic              i_flush,
    input  logic              i_wr,
    input  logic [DW-1:0]     i_data,
    input  logic              i_rd,
    output logic [DW-1:0]     o_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [LGFIFO:0]   o_fill
);
    localparam int DEPTH = 2 ** LGFIFO;
    localparam logic [LGFIFO:0] FULL_CNT = (LGFIFO + 1)'(DEPTH);

    logic [DW-1:0]     r_mem [DEPTH];
    logic [LGFIFO-1:0] r_wr_ptr;
    logic [LGFIFO-1:0] r_rd_ptr;
    logic [LGFIFO:0]   r_fill;
    logic              w_wr;
    logic              w_rd;

    assign w_wr = i_wr && !i_flush;
    assign w_rd = i_rd && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_fill <= r_fill + (LGFIFO + 1)'(1);
                2'b01:   r_fill <= r_fill - (LGFIFO + 1)'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset_n && !i_flush) begin
            assert (!(i_wr && o_full));
            assert (!(i_rd && o_empty));
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_fill == '0);
    assign o_full  = (r_fill == FULL_CNT);
    assign o_fill  = r_fill;

endmodule

// File: rtl/sram_wbqueue.sv
// Wishbone request queue in front of the SRAM controller: buffers pipelined requests,
// issues them one at a time downstream and returns acks in order.
module sram_wbqueue
    import sram_wbqueue_pkg::*;
#(
    parameter int AW     = 15,
    parameter int LGFIFO = 2
) (
    input  logic          i_clk,
    input  logic          i_areset_n,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic [3:0]    i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic [31:0]   o_wb_data,
    output logic          o_dn_cyc,
    output logic          o_dn_stb,
    output logic          o_dn_we,
    output logic [AW-1:0] o_dn_addr,
    output logic [31:0]   o_dn_data,
    output logic [3:0]    o_dn_sel,
    input  logic          i_dn_stall,
    input  logic          i_dn_ack,
    input  logic [31:0]   i_dn_data
);
    localparam int RW    = req_width(AW);
    localparam int DEPTH = 2 ** LGFIFO;

    state_t          r_state;
    logic            r_dn_cyc;
    logic            r_dn_stb;
    logic            r_dn_we;
    logic [AW-1:0]   r_dn_addr;
    logic [31:0]     r_dn_data;
    logic [3:0]      r_dn_sel;
    logic            r_wb_ack;
    logic [31:0]     r_wb_data;

    logic [RW-1:0]   w_head;
    logic            w_head_we;
    logic [AW-1:0]   w_head_addr;
    logic [31:0]     w_head_data;
    logic [3:0]      w_head_sel;
    logic            w_empty;
    logic            w_full;
    logic [LGFIFO:0] w_fill;
    logic            w_flush;
    logic            w_push;
    logic            w_pop;

    assign {w_head_we, w_head_addr, w_head_data, w_head_sel} = w_head;

    // Dropping cyc abandons everything queued behind the master's back
    assign w_flush = !i_wb_cyc;
    assign w_push  = i_wb_cyc && i_wb_stb && !w_full;
    assign w_pop   = i_wb_cyc && !w_empty &&
                     ((r_state == ST_IDLE) || ((r_state == ST_WAIT) && i_dn_ack));

    sram_reqfifo #(
        .DW     (RW),
        .LGFIFO (LGFIFO)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_areset_n (i_areset_n),
        .i_flush    (w_flush),
        .i_wr       (w_push),
        .i_data     ({i_wb_we, i_wb_addr, i_wb_data, i_wb_sel}),
        .i_rd       (w_pop),
        .o_data     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_fill     (w_fill)
    );

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_state   <= ST_IDLE;
            r_dn_cyc  <= 1'b0;
            r_dn_stb  <= 1'b0;
            r_dn_we   <= 1'b0;
            r_dn_addr <= '0;
            r_dn_data <= '0;
            r_dn_sel  <= '0;
            r_wb_ack  <= 1'b0;
            r_wb_data <= '0;
        end else begin
            r_wb_ack <= 1'b0;
            if (!i_wb_cyc) begin
                r_dn_cyc <= 1'b0;
                r_dn_stb <= 1'b0;
                r_state  <= ST_IDLE;
            end else begin
                if (w_pop) begin
                    r_dn_we   <= w_head_we;
                    r_dn_addr <= w_head_addr;
                    r_dn_data <= w_head_data;
                    r_dn_sel  <= w_head_sel;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (!w_empty) begin
                            r_dn_cyc <= 1'b1;
                            r_dn_stb <= 1'b1;
                            r_state  <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (!i_dn_stall) begin
                            r_dn_stb <= 1'b0;
                            r_state  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (i_dn_ack) begin
                            r_wb_ack  <= 1'b1;
                            r_wb_data <= i_dn_data;
                            // Keep the downstream cycle open when more work is waiting
                            if (!w_empty) begin
                                r_dn_stb <= 1'b1;
                                r_state  <= ST_REQ;
                            end else begin
                                r_dn_cyc <= 1'b0;
                                r_state  <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_areset_n) begin
            assert ((32'(w_fill) + ((r_state != ST_IDLE) ? 32'd1 : 32'd0)) <= 32'(DEPTH + 1));
        end
    end

    assign o_wb_stall = w_full;
    assign o_wb_ack   = r_wb_ack && i_wb_cyc;
    assign o_wb_data  = r_wb_data;
    assign o_dn_cyc   = r_dn_cyc;
    assign o_dn_stb   = r_dn_stb;
    assign o_dn_we    = r_dn_we;
    assign o_dn_addr  = r_dn_addr;
    assign o_dn_data  = r_dn_data;
    assign o_dn_sel   = r_dn_sel;

endmodule
